regfile_sb: RTL and testbench

- Parametrised integer register file for the RV32E core; successor to the fixed five-register file and its separate select mux.
- Provides configurable XLEN and register count, two combinational read ports, and one write port with byte strobes.
- Optional write-to-read bypass.
- Includes a pending-write scoreboard so the core can stall on load-use hazards from multi-cycle memory/SPI loads.

---
 rtl/regfile_sb.sv | 116 +++++++++++
 tb/tb_regfile_sb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file: XLEN x NREGS, 2 combinational read ports, 1 byte-strobed write port, plus a load-use scoreboard.
// Reads have zero latency (optional write forwarding); writes and busy marks land on the edge; no backpressure.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 16,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [XLEN/8-1:0] wr_be,
    input  logic [AW-1:0]     rs1_addr,
    input  logic [AW-1:0]     rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              busy_set,
    input  logic [AW-1:0]     busy_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              any_busy
);

    localparam int            IW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);

    if (NREGS > (1 << AW) || (XLEN % 8) != 0) begin : g_bad_cfg
        $error("regfile_sb: NREGS must fit in AW bits and XLEN must be a multiple of 8");
    end

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pend;

    logic             w_wr_ok;
    logic             w_busy_ok;
    logic             w_rs1_vld;
    logic             w_rs2_vld;
    logic             w_rs1_fwd;
    logic             w_rs2_fwd;
    logic [IW-1:0]    w_wr_idx;
    logic [IW-1:0]    w_busy_idx;
    logic [IW-1:0]    w_rs1_idx;
    logic [IW-1:0]    w_rs2_idx;
    logic [XLEN-1:0]  w_rs1_stored;
    logic [XLEN-1:0]  w_rs2_stored;
    logic [XLEN-1:0]  w_wr_merged;

    function automatic logic f_valid(input logic [AW-1:0] addr);
        return (addr != '0) && ({1'b0, addr} < NREGS_W);
    endfunction

    function automatic logic [XLEN-1:0] f_merge(input logic [XLEN-1:0]   old_v,
                                                input logic [XLEN-1:0]   new_v,
                                                input logic [XLEN/8-1:0] be);
        logic [XLEN-1:0] res;
        res = old_v;
        for (int b = 0; b < XLEN/8; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    assign w_wr_idx   = wr_addr[IW-1:0];
    assign w_busy_idx = busy_addr[IW-1:0];
    assign w_rs1_idx  = rs1_addr[IW-1:0];
    assign w_rs2_idx  = rs2_addr[IW-1:0];

    // rst_n gating keeps the forwarding path from leaking wr_data while held in reset.
    assign w_wr_ok   = wr_en && rst_n && f_valid(wr_addr);
    assign w_busy_ok = busy_set && f_valid(busy_addr);
    assign w_rs1_vld = f_valid(rs1_addr);
    assign w_rs2_vld = f_valid(rs2_addr);

    assign w_rs1_fwd = (BYPASS != 0) && w_wr_ok && (wr_addr == rs1_addr);
    assign w_rs2_fwd = (BYPASS != 0) && w_wr_ok && (wr_addr == rs2_addr);

    assign w_rs1_stored = w_rs1_vld ? r_regs[w_rs1_idx] : '0;
    assign w_rs2_stored = w_rs2_vld ? r_regs[w_rs2_idx] : '0;
    assign w_wr_merged  = f_merge(r_regs[w_wr_idx], wr_data, wr_be);

    assign rs1_data = w_rs1_fwd ? f_merge(w_rs1_stored, wr_data, wr_be) : w_rs1_stored;
    assign rs2_data = w_rs2_fwd ? f_merge(w_rs2_stored, wr_data, wr_be) : w_rs2_stored;

    // A forwarded operand is already available, so its pending bit no longer stalls.
    assign rs1_busy = w_rs1_vld && r_pend[w_rs1_idx] && !w_rs1_fwd;
    assign rs2_busy = w_rs2_vld && r_pend[w_rs2_idx] && !w_rs2_fwd;
    assign any_busy = |r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_wr_ok && (w_wr_idx == IW'(i))) r_regs[i] <= w_wr_merged;
            end
        end
    end

    // A new load issued on the same edge as a retiring write keeps the register pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_busy_ok && (w_busy_idx == IW'(i))) begin
                    r_pend[i] <= 1'b1;
                end else if (w_wr_ok && (w_wr_idx == IW'(i))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one instance with forwarding, one without, sharing all inputs.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        busy_set;
    logic [4:0]  busy_addr;

    logic [31:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
    logic        b_rs1_busy, b_rs2_busy, b_any_busy;
    logic        n_rs1_busy, n_rs2_busy, n_any_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_reg [16];

    regfile_sb #(.XLEN(32), .NREGS(16), .AW(5), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy), .any_busy(b_any_busy)
    );

    regfile_sb #(.XLEN(32), .NREGS(16), .AW(5), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy), .any_busy(n_any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0; wr_be = 4'h0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rs1_addr = '0; rs2_addr = '0; busy_set = 1'b0; busy_addr = '0;

        // Held in reset with a live write: nothing is forwarded or stored.
        #12;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        rs1_addr = 5'd3; rs2_addr = 5'd3; busy_set = 1'b1; busy_addr = 5'd3;
        #1;
        check("rst_fwd_rs1", b_rs1_data, 32'h0);
        check("rst_fwd_rs2", b_rs2_data, 32'h0);
        check("rst_busy", {29'd0, b_rs1_busy, b_rs2_busy, b_any_busy}, 32'h0);
        step();
        wr_en = 1'b0; wr_be = 4'h0; busy_set = 1'b0;
        #2 rst_n = 1'b1;
        step();

        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
            #1;
            check($sformatf("rst_rd_rs1_x%0d", a), b_rs1_data, 32'h0);
            check($sformatf("rst_rd_rs2_x%0d", 31 - a), n_rs2_data, 32'h0);
            check($sformatf("rst_busy_x%0d", a),
                  {26'd0, b_rs1_busy, b_rs2_busy, b_any_busy, n_rs1_busy, n_rs2_busy, n_any_busy}, 32'h0);
        end

        for (int i = 1; i < 16; i++) begin
            exp_reg[i] = 32'h0101_0101 * i;
            wr(5'(i), exp_reg[i], 4'hF);
        end
        exp_reg[0] = 32'h0;

        wr(5'd5, 32'hDEAD_BEEF, 4'hF);
        wr(5'd5, 32'h1122_3344, 4'b0101);
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        check("be_merge_x5", b_rs1_data, 32'hDE22_BE44);
        check("be_merge_x5_nb", n_rs2_data, 32'hDE22_BE44);
        exp_reg[5] = 32'hDE22_BE44;
        wr(5'd5, 32'h0000_0000, 4'h0);
        check("be_zero_noop", b_rs1_data, 32'hDE22_BE44);

        wr(5'd0, 32'hFFFF_FFFF, 4'hF);
        wr(5'd20, 32'h1234_5678, 4'hF);
        rs1_addr = 5'd0; rs2_addr = 5'd20;
        #1;
        check("x0_reads_0", b_rs1_data, 32'h0);
        check("x20_reads_0", b_rs2_data, 32'h0);
        for (int i = 1; i < 16; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(i);
            #1;
            check($sformatf("keep_x%0d", i), b_rs1_data, exp_reg[i]);
            check($sformatf("keep_nb_x%0d", i), n_rs2_data, exp_reg[i]);
        end

        // Same-cycle forwarding vs. stored-only read.
        step();
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5_A5A5; wr_be = 4'hF;
        #1;
        check("byp_rs1", b_rs1_data, 32'hA5A5_A5A5);
        check("byp_rs2", b_rs2_data, 32'hA5A5_A5A5);
        check("nobyp_old", n_rs1_data, 32'h0303_0303);
        step();
        wr_en = 1'b0;
        #1;
        check("nobyp_new", n_rs1_data, 32'hA5A5_A5A5);
        wr_en = 1'b1; wr_data = 32'h5A5A_5A5A; wr_be = 4'b0011;
        #1;
        check("byp_partial", b_rs2_data, 32'hA5A5_5A5A);
        check("nobyp_partial_old", n_rs2_data, 32'hA5A5_A5A5);
        step();
        wr_en = 1'b0; wr_be = 4'h0;

        // Scoreboard set / clear / set-wins.
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        busy_set = 1'b1; busy_addr = 5'd7;
        #1;
        check("sb_not_yet", {31'd0, b_rs1_busy}, 32'd0);
        step();
        busy_set = 1'b0;
        #1;
        check("sb_set_rs1", {31'd0, b_rs1_busy}, 32'd1);
        check("sb_set_any", {31'd0, b_any_busy}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hFFFF_FFFF; wr_be = 4'h0;
        #1;
        check("sb_mask_byp", {31'd0, b_rs1_busy}, 32'd0);
        check("sb_nomask_nb", {31'd0, n_rs1_busy}, 32'd1);
        check("sb_any_unmasked", {31'd0, b_any_busy}, 32'd1);
        step();
        wr_en = 1'b0;
        #1;
        check("sb_cleared", {31'd0, b_rs1_busy}, 32'd0);
        check("sb_cleared_any", {31'd0, b_any_busy}, 32'd0);
        check("sb_be0_data", b_rs1_data, 32'h0707_0707);
        busy_set = 1'b1; busy_addr = 5'd7;
        step();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h7777_7777; wr_be = 4'hF;
        step();
        busy_set = 1'b0; wr_en = 1'b0;
        #1;
        check("sb_set_wins", {31'd0, b_rs1_busy}, 32'd1);
        check("sb_set_wins_nb", {31'd0, n_rs2_busy}, 32'd1);
        check("sb_set_wins_data", b_rs1_data, 32'h7777_7777);
        wr(5'd7, 32'h7777_7777, 4'hF);
        busy_set = 1'b1; busy_addr = 5'd0;
        step();
        busy_addr = 5'd20;
        step();
        busy_set = 1'b0;
        rs1_addr = 5'd20; rs2_addr = 5'd4;
        #1;
        check("sb_invalid_any", {31'd0, b_any_busy}, 32'd0);
        check("sb_invalid_rs", {30'd0, b_rs1_busy, b_rs2_busy}, 32'd0);

        // Mid-cycle reset pulse discards stored data, pending bits and the in-flight write.
        wr(5'd2, 32'h0000_0055, 4'hF);
        busy_set = 1'b1; busy_addr = 5'd4;
        step();
        busy_set = 1'b0;
        rs1_addr = 5'd2; rs2_addr = 5'd4;
        #1;
        check("pre_rst_x2", b_rs1_data, 32'h0000_0055);
        check("pre_rst_busy", {30'd0, b_rs2_busy, b_any_busy}, 32'd3);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        rst_n = 1'b0;
        #1;
        check("rst_async_rs1", b_rs1_data, 32'h0);
        check("rst_async_nb", n_rs1_data, 32'h0);
        check("rst_async_busy", {29'd0, b_rs2_busy, b_any_busy, n_any_busy}, 32'd0);
        #1;
        rst_n = 1'b1; wr_en = 1'b0; wr_be = 4'h0;
        step();
        check("post_rst_x2", b_rs1_data, 32'h0);
        check("post_rst_any", {30'd0, b_any_busy, n_any_busy}, 32'd0);
        rs1_addr = 5'd5;
        #1;
        check("post_rst_x5", b_rs1_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
